// File: rtl/adjacency_map.sv
// Adjacency map responder: captures directed edges into per-source linked lists during load,
// then streams the destinations of one queried node per request.
module adjacency_map #(
  parameter int unsigned MAX_NODES       = 1024,
  parameter int unsigned MAX_EDGES       = 2048,
  parameter int unsigned NODE_WIDTH      = $clog2(MAX_NODES),
  parameter int unsigned EDGE_ADDR_WIDTH = $clog2(MAX_EDGES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       edge_valid,
  input  logic [NODE_WIDTH-1:0]      edge_src,
  input  logic [NODE_WIDTH-1:0]      edge_dst,
  input  logic                       decoding_done,
  output logic [EDGE_ADDR_WIDTH:0]   edge_count,
  output logic                       edge_overflow,
  output logic                       query_ready,
  input  logic                       query_valid,
  input  logic [NODE_WIDTH-1:0]      query_data,
  output logic                       reply_valid,
  input  logic                       reply_ready,
  output logic [NODE_WIDTH-1:0]      reply_data,
  output logic                       reply_last,
  output logic                       reply_no_edges_found
);

  localparam int unsigned EW = NODE_WIDTH + EDGE_ADDR_WIDTH + 1;
  localparam logic [EDGE_ADDR_WIDTH:0] EdgeCap = (EDGE_ADDR_WIDTH + 1)'(MAX_EDGES);

  typedef enum logic [2:0] {StLoad, StIdle, StHeadRd, StEdgeRd, StReply} state_e;

  state_e                     state_q, state_d;
  logic [EDGE_ADDR_WIDTH:0]   count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic [MAX_NODES-1:0]       head_valid_q;
  logic [NODE_WIDTH-1:0]      query_q, query_d;
  logic [EDGE_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [EDGE_ADDR_WIDTH-1:0] next_ptr_q, next_ptr_d;
  logic                       rvalid_q, rvalid_d;
  logic [NODE_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       rlast_q, rlast_d;
  logic                       rnone_q, rnone_d;

  logic [EDGE_ADDR_WIDTH-1:0] head_ptr_mem [MAX_NODES];
  logic [EW-1:0]              edge_mem [MAX_EDGES];
  logic [EDGE_ADDR_WIDTH-1:0] head_rd_q;
  logic [EW-1:0]              edge_rd_q;
  logic [NODE_WIDTH-1:0]      head_raddr;

  logic                       pipe_valid_q;
  logic [EDGE_ADDR_WIDTH-1:0] pipe_slot_q;
  logic [NODE_WIDTH-1:0]      pipe_dst_q;
  logic                       pipe_hv_q;

  logic                       accept;
  logic [EDGE_ADDR_WIDTH-1:0] slot;
  logic [NODE_WIDTH-1:0]      edge_rd_dst;
  logic [EDGE_ADDR_WIDTH-1:0] edge_rd_next;
  logic                       edge_rd_nvalid;

  assign accept = (state_q == StLoad) && edge_valid && (count_q != EdgeCap);
  assign slot   = count_q[EDGE_ADDR_WIDTH-1:0];

  assign edge_rd_dst    = edge_rd_q[EW-1 -: NODE_WIDTH];
  assign edge_rd_next   = edge_rd_q[EDGE_ADDR_WIDTH:1];
  assign edge_rd_nvalid = edge_rd_q[0];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    query_d    = query_q;
    ptr_d      = ptr_q;
    next_ptr_d = next_ptr_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rlast_d    = rlast_q;
    rnone_d    = rnone_q;
    head_raddr = query_data;
    unique case (state_q)
      StLoad: begin
        head_raddr = edge_src;
        if (accept) count_d = count_q + 1'b1;
        if (edge_valid && !accept) overflow_d = 1'b1;
        if (decoding_done) state_d = StIdle;
      end
      StIdle: begin
        if (query_valid) begin
          query_d = query_data;
          state_d = StHeadRd;
        end
      end
      StHeadRd: begin
        if (head_valid_q[query_q]) begin
          ptr_d   = head_rd_q;
          state_d = StEdgeRd;
        end else begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rlast_d  = 1'b1;
          rnone_d  = 1'b1;
          state_d  = StReply;
        end
      end
      StEdgeRd: begin
        rvalid_d   = 1'b1;
        rdata_d    = edge_rd_dst;
        rlast_d    = !edge_rd_nvalid;
        rnone_d    = 1'b0;
        next_ptr_d = edge_rd_next;
        state_d    = StReply;
      end
      StReply: begin
        if (reply_ready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          rnone_d  = 1'b0;
          if (rlast_q) begin
            state_d = StIdle;
          end else begin
            ptr_d   = next_ptr_q;
            state_d = StEdgeRd;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StLoad;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      head_valid_q <= '0;
      query_q      <= '0;
      ptr_q        <= '0;
      next_ptr_q   <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      rlast_q      <= 1'b0;
      rnone_q      <= 1'b0;
      pipe_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      query_q      <= query_d;
      ptr_q        <= ptr_d;
      next_ptr_q   <= next_ptr_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rlast_q      <= rlast_d;
      rnone_q      <= rnone_d;
      pipe_valid_q <= accept;
      if (accept) head_valid_q[edge_src] <= 1'b1;
    end
  end

  // The head pointer is updated in the capture cycle and the old head is read in the same
  // cycle, so back-to-back same-source edges always see the previous edge's slot; the edge
  // word is completed one cycle later from that read.
  always_ff @(posedge clk) begin
    if (accept) head_ptr_mem[edge_src] <= slot;
    head_rd_q   <= head_ptr_mem[head_raddr];
    pipe_slot_q <= slot;
    pipe_dst_q  <= edge_dst;
    pipe_hv_q   <= head_valid_q[edge_src];
    if (pipe_valid_q) edge_mem[pipe_slot_q] <= {pipe_dst_q, head_rd_q, pipe_hv_q};
    edge_rd_q   <= edge_mem[ptr_d];
  end

  assign edge_count           = count_q;
  assign edge_overflow        = overflow_q;
  assign query_ready          = (state_q == StIdle);
  assign reply_valid          = rvalid_q;
  assign reply_data           = rdata_q;
  assign reply_last           = rlast_q;
  assign reply_no_edges_found = rnone_q;

endmodule

// File: tb/tb_adjacency_map.sv
// Scoreboard bench for adjacency_map: a default-size instance for load/query/reset scenarios
// and a 4-edge instance for storage overflow.
module tb_adjacency_map;

  localparam int NW = 10;
  localparam int SW = 4;

  typedef struct packed {
    logic [NW-1:0] data;
    logic          last;
    logic          none;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          edge_valid = 1'b0;
  logic [NW-1:0] edge_src = '0;
  logic [NW-1:0] edge_dst = '0;
  logic          decoding_done = 1'b0;
  logic [11:0]   edge_count;
  logic          edge_overflow;
  logic          query_ready;
  logic          query_valid = 1'b0;
  logic [NW-1:0] query_data = '0;
  logic          reply_valid;
  logic          reply_ready = 1'b0;
  logic [NW-1:0] reply_data;
  logic          reply_last;
  logic          reply_no_edges_found;

  logic          s_edge_valid = 1'b0;
  logic [SW-1:0] s_edge_src = '0;
  logic [SW-1:0] s_edge_dst = '0;
  logic          s_decoding_done = 1'b0;
  logic [2:0]    s_edge_count;
  logic          s_edge_overflow;
  logic          s_query_ready;
  logic          s_query_valid = 1'b0;
  logic [SW-1:0] s_query_data = '0;
  logic          s_reply_valid;
  logic          s_reply_ready = 1'b0;
  logic [SW-1:0] s_reply_data;
  logic          s_reply_last;
  logic          s_reply_no_edges_found;

  adjacency_map dut (
    .clk(clk), .rst_n(rst_n), .edge_valid(edge_valid), .edge_src(edge_src),
    .edge_dst(edge_dst), .decoding_done(decoding_done), .edge_count(edge_count),
    .edge_overflow(edge_overflow), .query_ready(query_ready), .query_valid(query_valid),
    .query_data(query_data), .reply_valid(reply_valid), .reply_ready(reply_ready),
    .reply_data(reply_data), .reply_last(reply_last),
    .reply_no_edges_found(reply_no_edges_found)
  );

  adjacency_map #(.MAX_NODES(16), .MAX_EDGES(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .edge_valid(s_edge_valid), .edge_src(s_edge_src),
    .edge_dst(s_edge_dst), .decoding_done(s_decoding_done), .edge_count(s_edge_count),
    .edge_overflow(s_edge_overflow), .query_ready(s_query_ready),
    .query_valid(s_query_valid), .query_data(s_query_data), .reply_valid(s_reply_valid),
    .reply_ready(s_reply_ready), .reply_data(s_reply_data), .reply_last(s_reply_last),
    .reply_no_edges_found(s_reply_no_edges_found)
  );

  int n_chk = 0;
  int n_fail = 0;
  beat_t sb[$];
  beat_t s_sb[$];
  logic [NW-1:0] m_src[$];
  logic [NW-1:0] m_dst[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_edge(input logic [NW-1:0] src, input logic [NW-1:0] dst,
                           input logic done);
    edge_valid = 1'b1;
    edge_src = src;
    edge_dst = dst;
    decoding_done = done;
    tick();
    edge_valid = 1'b0;
    decoding_done = 1'b0;
    m_src.push_back(src);
    m_dst.push_back(dst);
  endtask

  // Newest edge first; the oldest matching edge closes the reply.
  task automatic push_expected(input logic [NW-1:0] node);
    int oldest;
    beat_t b;
    oldest = -1;
    for (int i = 0; i < m_src.size(); i++) begin
      if (m_src[i] == node && oldest < 0) oldest = i;
    end
    if (oldest < 0) begin
      b.data = '0;
      b.last = 1'b1;
      b.none = 1'b1;
      sb.push_back(b);
    end else begin
      for (int i = m_src.size() - 1; i >= oldest; i--) begin
        if (m_src[i] == node) begin
          b.data = m_dst[i];
          b.last = (i == oldest);
          b.none = 1'b0;
          sb.push_back(b);
        end
      end
    end
  endtask

  task automatic do_query(input logic [NW-1:0] node, input int stall);
    int lat;
    bit fin;
    beat_t exp;
    push_expected(node);
    n_chk++;
    if (query_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL query_ready_idle node=%0d got=%b want=1", node, query_ready);
    end
    query_valid = 1'b1;
    query_data = node;
    tick();
    query_valid = 1'b0;
    n_chk++;
    if (query_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL query_ready_busy node=%0d got=%b want=0", node, query_ready);
    end
    lat = 1;
    while (reply_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    exp = sb[0];
    n_chk++;
    if (lat != (exp.none ? 2 : 3)) begin
      n_fail++;
      $display("FAIL first_beat_latency node=%0d got=%0d want=%0d", node, lat,
               exp.none ? 2 : 3);
    end
    fin = 1'b0;
    while (!fin) begin
      if (reply_valid !== 1'b1) begin
        n_chk++;
        n_fail++;
        $display("FAIL beat_timeout node=%0d got reply_valid=%b want=1", node, reply_valid);
        sb.delete();
        break;
      end
      exp = sb.pop_front();
      n_chk++;
      if ({reply_data, reply_last, reply_no_edges_found} !== {exp.data, exp.last, exp.none})
      begin
        n_fail++;
        $display("FAIL beat node=%0d got data=%0d last=%b none=%b want data=%0d last=%b none=%b",
                 node, reply_data, reply_last, reply_no_edges_found, exp.data, exp.last,
                 exp.none);
      end
      for (int s = 0; s < stall; s++) begin
        tick();
        n_chk++;
        if ({reply_valid, reply_data, reply_last, reply_no_edges_found} !==
            {1'b1, exp.data, exp.last, exp.none}) begin
          n_fail++;
          $display("FAIL stall_stable node=%0d cyc=%0d got v=%b data=%0d last=%b none=%b",
                   node, s, reply_valid, reply_data, reply_last, reply_no_edges_found);
        end
      end
      reply_ready = 1'b1;
      tick();
      reply_ready = 1'b0;
      n_chk++;
      if ({reply_valid, reply_last, reply_no_edges_found} !== 3'b000) begin
        n_fail++;
        $display("FAIL beat_drop node=%0d got v=%b last=%b none=%b want 000", node,
                 reply_valid, reply_last, reply_no_edges_found);
      end
      if (exp.last) begin
        n_chk++;
        if (query_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL ready_after_last node=%0d got=%b want=1", node, query_ready);
        end
        fin = 1'b1;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_chk++;
    if ({query_ready, reply_valid, reply_last, reply_no_edges_found, edge_overflow} !== 5'b0 ||
        edge_count !== 12'd0 || reply_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state got qr=%b rv=%b rl=%b rn=%b ov=%b cnt=%0d data=%0d want all 0",
               query_ready, reply_valid, reply_last, reply_no_edges_found, edge_overflow,
               edge_count, reply_data);
    end
    n_chk++;
    if ({s_query_ready, s_reply_valid, s_edge_overflow} !== 3'b0 || s_edge_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state_small got qr=%b rv=%b ov=%b cnt=%0d want all 0",
               s_query_ready, s_reply_valid, s_edge_overflow, s_edge_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    load_edge(10'd3, 10'd5, 1'b0);
    load_edge(10'd3, 10'd7, 1'b0);
    load_edge(10'd4, 10'd3, 1'b0);
    n_chk++;
    if (edge_count !== 12'd3 || query_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_count got cnt=%0d qr=%b want cnt=3 qr=0", edge_count, query_ready);
    end
    // Same-source edges on consecutive cycles; the last one shares the done cycle.
    load_edge(10'd1, 10'd2, 1'b0);
    load_edge(10'd1, 10'd4, 1'b0);
    load_edge(10'd1, 10'd6, 1'b1);
    n_chk++;
    if (edge_count !== 12'd6 || query_ready !== 1'b1 || edge_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL load_done got cnt=%0d qr=%b ov=%b want cnt=6 qr=1 ov=0", edge_count,
               query_ready, edge_overflow);
    end
    edge_valid = 1'b1;
    edge_src = 10'd9;
    edge_dst = 10'd1;
    tick();
    edge_valid = 1'b0;
    n_chk++;
    if (edge_count !== 12'd6) begin
      n_fail++;
      $display("FAIL idle_edge_ignored got cnt=%0d want=6", edge_count);
    end
  endtask

  task automatic test_queries();
    do_query(10'd3, 0);
    do_query(10'd9, 5);
    do_query(10'd1, 0);
    do_query(10'd4, 2);
    do_query(10'd1, 1);
  endtask

  task automatic test_overflow();
    logic [SW-1:0] srcs [5];
    logic [SW-1:0] dsts [5];
    beat_t b;
    int w;
    srcs = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd0};
    dsts = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    for (int i = 0; i < 5; i++) begin
      s_edge_valid = 1'b1;
      s_edge_src = srcs[i];
      s_edge_dst = dsts[i];
      s_decoding_done = (i == 4);
      tick();
    end
    s_edge_valid = 1'b0;
    s_decoding_done = 1'b0;
    n_chk++;
    if (s_edge_count !== 3'd4 || s_edge_overflow !== 1'b1 || s_query_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_state got cnt=%0d ov=%b qr=%b want cnt=4 ov=1 qr=1",
               s_edge_count, s_edge_overflow, s_query_ready);
    end
    b = '0;
    b.data = 10'd2;
    s_sb.push_back(b);
    b.data = 10'd1;
    b.last = 1'b1;
    s_sb.push_back(b);
    s_query_valid = 1'b1;
    s_query_data = 4'd0;
    tick();
    s_query_valid = 1'b0;
    while (s_sb.size() > 0) begin
      w = 0;
      while (s_reply_valid !== 1'b1 && w < 10) begin
        tick();
        w++;
      end
      b = s_sb.pop_front();
      n_chk++;
      if (s_reply_valid !== 1'b1 || s_reply_data !== b.data[SW-1:0] ||
          s_reply_last !== b.last || s_reply_no_edges_found !== 1'b0) begin
        n_fail++;
        $display("FAIL overflow_beat got v=%b data=%0d last=%b none=%b want data=%0d last=%b",
                 s_reply_valid, s_reply_data, s_reply_last, s_reply_no_edges_found,
                 b.data[SW-1:0], b.last);
      end
      s_reply_ready = 1'b1;
      tick();
      s_reply_ready = 1'b0;
    end
    n_chk++;
    if (s_query_ready !== 1'b1 || s_reply_valid !== 1'b0 || s_edge_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_end got qr=%b rv=%b ov=%b want qr=1 rv=0 ov=1", s_query_ready,
               s_reply_valid, s_edge_overflow);
    end
  endtask

  task automatic test_reset_mid_reply();
    int w;
    query_valid = 1'b1;
    query_data = 10'd3;
    tick();
    query_valid = 1'b0;
    w = 0;
    while (reply_valid !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    n_chk++;
    if (reply_valid !== 1'b1 || reply_data !== 10'd7 || reply_last !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_first got v=%b data=%0d last=%b want v=1 data=7 last=0",
               reply_valid, reply_data, reply_last);
    end
    reply_ready = 1'b1;
    tick();
    reply_ready = 1'b0;
    tick();
    n_chk++;
    if (reply_valid !== 1'b1 || reply_data !== 10'd5 || reply_last !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_second got v=%b data=%0d last=%b want v=1 data=5 last=1",
               reply_valid, reply_data, reply_last);
    end
    rst_n = 1'b0;
    reply_ready = 1'b1;
    tick();
    reply_ready = 1'b0;
    rst_n = 1'b1;
    n_chk++;
    if ({reply_valid, query_ready, reply_last, reply_no_edges_found} !== 4'b0 ||
        edge_count !== 12'd0) begin
      n_fail++;
      $display("FAIL midrst_abort got rv=%b qr=%b rl=%b rn=%b cnt=%0d want all 0",
               reply_valid, query_ready, reply_last, reply_no_edges_found, edge_count);
    end
    m_src.delete();
    m_dst.delete();
    load_edge(10'd2, 10'd8, 1'b1);
    n_chk++;
    if (edge_count !== 12'd1) begin
      n_fail++;
      $display("FAIL reload_count got cnt=%0d want=1", edge_count);
    end
    do_query(10'd3, 0);
    do_query(10'd1, 0);
    do_query(10'd2, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_queries();
    test_overflow();
    test_reset_mid_reply();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adjacency_map.md
Name: adjacency_map

Overview:
- Responder end of the adjacency map query/reply interface used by the topological sort block.
- During input decoding it captures directed edges (src -> dst) into per-source linked lists.
- After decoding it answers one query at a time: given a node, it streams every destination node of that node's outgoing edges, or returns a single "no edges" beat.

Parameters:
MAX_NODES, 1024, node index space; node IDs are 0..MAX_NODES-1.
MAX_EDGES, 2048, edge storage capacity.
NODE_WIDTH, $clog2(MAX_NODES), node ID width.
EDGE_ADDR_WIDTH, $clog2(MAX_EDGES), edge slot index width (local).

Ports:
clk  in  1  single clock; all logic on rising edge.
rst_n  in  1  synchronous, active-low reset.
edge_valid  in  1  edge capture strobe; one edge per cycle, no backpressure.
edge_src  in  NODE_WIDTH  edge source node.
edge_dst  in  NODE_WIDTH  edge destination node.
decoding_done  in  1  level; high once all edges have been presented.
edge_count  out  EDGE_ADDR_WIDTH+1  number of edges stored.
edge_overflow  out  1  sticky; an edge was dropped because storage was full.
query_ready  out  1  responder is idle and can accept a query.
query_valid  in  1  query request.
query_data  in  NODE_WIDTH  node whose outgoing edges are requested.
reply_valid  out  1  reply beat present.
reply_ready  in  1  consumer accepts the beat.
reply_data  out  NODE_WIDTH  destination node of the current edge; 0 on a no-edges beat.
reply_last  out  1  final beat of the current reply.
reply_no_edges_found  out  1  queried node has no outgoing edges; always paired with reply_last=1.

Behaviour:
- Storage:
  - head_valid: flop vector [MAX_NODES], cleared by reset.
  - head_ptr RAM [MAX_NODES] x EDGE_ADDR_WIDTH.
  - edge RAM [MAX_EDGES] holding {dst, next_ptr, next_valid}.
  - All RAM reads are synchronous (1-cycle).
- Reset (rst_n=0 at a clock edge):
  - state = LOAD; edge_count=0; edge_overflow=0; head_valid all 0.
  - query_ready=0; reply_valid=0; reply_last=0; reply_no_edges_found=0; reply_data=0.
  - Reset mid-load or mid-reply aborts immediately; no beat is completed.
- States: LOAD, IDLE, HEAD_RD, EDGE_RD, REPLY.
- LOAD:
  - On each edge_valid with edge_count<MAX_EDGES: slot e=edge_count.
  - Write edge[e] = {edge_dst, head_ptr[src], head_valid[src]}.
  - Set head_ptr[src]=e and head_valid[src]=1; increment edge_count.
  - Insertion is at list head, so replies come out in reverse insertion order per source.
  - Same-source edges on consecutive cycles must chain correctly. Keep a bypass of the last head write; the RAM read-modify-write must not lose an edge.
  - edge_valid with edge_count==MAX_EDGES: edge dropped; edge_overflow<=1 (sticky until reset).
  - Duplicate edges are stored as distinct entries.
  - decoding_done=1: an edge presented in the same cycle is still accepted; next state IDLE.
  - query_ready=0 throughout LOAD.
- IDLE:
  - query_ready=1.
  - Handshake at cycle T (query_valid & query_ready) latches query_data; next state HEAD_RD; query_ready=0 from T+1.
  - edge_valid is ignored in every state other than LOAD.
- HEAD_RD (T+1): read head_valid and head_ptr[query].
  - Not valid: reply_valid=1 at T+2 with reply_data=0, reply_last=1, reply_no_edges_found=1; state REPLY.
  - Valid: state EDGE_RD with ptr=head_ptr.
- EDGE_RD: read edge[ptr]; next cycle reply_valid=1 with reply_data=dst and reply_last=!next_valid; state REPLY.
  - First edge beat therefore appears at T+3.
- REPLY:
  - Outputs held stable while reply_valid & !reply_ready. Beats may be stalled arbitrarily long.
  - Handshake at H on a non-last beat: reply_valid=0 at H+1; ptr=next_ptr; EDGE_RD; next beat valid at H+2.
  - Handshake at H on a last beat: reply_valid, reply_last and reply_no_edges_found drop at H+1; state IDLE; query_ready=1 at H+1.
- reply_no_edges_found is 0 on every edge beat.
- Exactly one beat per stored edge of the queried source.
- Queries are never lost or reordered; only one query is outstanding at a time.

Test Plan:
- Reset, then load edges (3->5), (3->7), (4->3), decoding_done -> edge_count=3, query_ready=1 the cycle after done.
- Query 3 -> beats 7 (last=0) then 5 (last=1). First beat at T+3, second beat two cycles after the first handshake, no_edges=0.
- Query 9 (no edges) -> single beat at T+2: data=0, last=1, no_edges=1. reply_ready held low 5 cycles -> beat stays stable; after handshake query_ready=1 next cycle.
- Back-to-back same-source edges (1->2), (1->4), (1->6) on consecutive cycles, query 1 -> beats 6, 4, 2; last=1 only on 2.
- MAX_EDGES=4, load 5 edges -> edge_count=4, edge_overflow=1, 5th edge absent from its source's reply.
- Assert rst_n=0 during the second beat of the query-3 reply -> reply_valid=0 and query_ready=0 next cycle, edge_count=0. Any post-reset query (after a fresh load plus done) of an unloaded node -> no_edges=1.
